cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
// Responder end of the cache<->memory request interface: serves the dcache (read/write, word-wide)
// and the icache (read-only), arbitrates them onto the single-ported RAM and returns wait/load.
// Sits between the cache pair and the RAM model. Completion is signalled by a one-cycle drop of
// the requester's wait line. Drives nothing into the datapath directly.
// PARAMETERS
// STARVE_MAX  4             consecutive dcache grants allowed while iREN is pending before icache is forced
// ERR_WORD    32'hBAD1BAD1  value returned on the load bus when RAM reports ERROR
// PORTS
// CLK        in   1   clock, all state on rising edge
// nRST       in   1   synchronous active-low reset (sampled on rising CLK)
// iREN       in   1   icache read request, held until iwait==0
// iaddr      in   32  icache word address
// iwait      out  1   1 = icache request not complete; 0 for exactly the completion cycle
// iload      out  32  icache read data, valid only when iwait==0
// dREN       in   1   dcache read request
// dWEN       in   1   dcache write request (wins over dREN if both high)
// daddr      in   32  dcache word address
// dstore     in   32  dcache write data
// dwait      out  1   1 = dcache request not complete; 0 for exactly the completion cycle
// dload      out  32  dcache read data, valid only when dwait==0
// ramREN     out  1   RAM read strobe
// ramWEN     out  1   RAM write strobe
// ramaddr    out  32  RAM address
// ramstore   out  32  RAM write data
// ramload    in   32  RAM read data
// ramstate   in   2   FREE=0, BUSY=1, ACCESS=2, ERROR=3
// err_count  out  8   saturating count of ERROR completions
// BEHAVIOUR
// - Reset (nRST==0 at edge): state=IDLE, d_streak=0, err_count=0. Reset outputs: ramREN=ramWEN=0,
//   ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0. Reset mid-access abandons it; no completion issued.
// - FSM states: IDLE, D_READ, D_WRITE, I_READ (registered); RAM/wait/load outputs combinational from state.
// - IDLE: no RAM strobes, both waits 1. Grant at edge: dWEN->D_WRITE, else dREN->D_READ, else iREN->I_READ;
//   dcache has priority EXCEPT when iREN && d_streak==STARVE_MAX -> I_READ.
// - D_READ/D_WRITE: ramREN/ramWEN=1, ramaddr=daddr, ramstore=dstore (live inputs). I_READ: ramREN=1, ramaddr=iaddr.
// - Completion: in a grant state with ramstate==ACCESS -> granted wait=0, load=ramload (write: dload=0)
//   for that cycle only; next state IDLE. ramstate==ERROR -> same, but load=ERR_WORD, err_count+1 (sat 255).
// - FREE/BUSY in grant state: hold state, waits stay 1.
// - Requester drops its strobe while granted (no completion this cycle) -> IDLE next edge, no completion.
// - Non-granted requester always sees wait=1 and load=0.
// - Latency: request seen in IDLE cycle N -> RAM strobe from N+1 -> wait=0 in first ACCESS cycle;
//   one mandatory IDLE bubble between consecutive transactions (cache retargets address in that bubble).
// - d_streak: +1 on each dcache grant made while iREN==1 (sat STARVE_MAX); cleared on icache grant
//   or any IDLE cycle with iREN==0.
// - dREN&&dWEN together: treated as write; never drive ramREN and ramWEN high together.
// TESTING
// - dREN=1 daddr=0x40, RAM ACCESS after 2 BUSY, ramload=0xCAFE0001 -> dwait=0 once, dload=0xCAFE0001, back to IDLE.
// - dWEN=1 daddr=0x44 dstore=0x12345678 -> ramWEN=1 ramaddr=0x44 ramstore=0x12345678 until ACCESS, then dwait=0 one cycle.
// - iREN and dREN asserted together, held for 6 dcache transactions -> grants D,D,D,D,I (STARVE_MAX=4), iwait=0 on 5th.
// - ramstate=ERROR during I_READ -> iwait=0, iload=0xBAD1BAD1, err_count 0->1; 256 errors -> err_count stays 255.
// - dREN dropped while granted and ramstate=BUSY -> IDLE next cycle, dwait never 0, no strobes in IDLE.
// - nRST=0 during D_WRITE with ramstate=BUSY -> next edge all outputs at reset values, no completion seen.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Arbitrates dcache (read/write) and icache (read) requests onto a single-ported RAM.
// dcache has priority, but icache is forced through after STARVE_MAX back-to-back dcache grants.
module cache_mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter logic [31:0] ERR_WORD   = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {StIdle, StDRead, StDWrite, StIRead} state_t;

    localparam logic [1:0] RamAccess = 2'd2;
    localparam logic [1:0] RamError  = 2'd3;
    localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

    state_t      state_q, state_d;
    logic [7:0]  streak_q, streak_d;
    logic [7:0]  err_q, err_d;
    logic        done;
    logic [31:0] rdata;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= StIdle;
            streak_q <= 8'd0;
            err_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            err_q    <= err_d;
        end
    end

    assign done      = (ramstate == RamAccess) || (ramstate == RamError);
    assign rdata     = (ramstate == RamError) ? ERR_WORD : ramload;
    assign err_count = err_q;

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        err_d    = err_q;
        iwait    = 1'b1;
        iload    = 32'd0;
        dwait    = 1'b1;
        dload    = 32'd0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;

        case (state_q)
            StIdle: begin
                if (!iREN) begin
                    streak_d = 8'd0;
                end
                if (iREN && streak_q == StarveMax) begin
                    state_d  = StIRead;
                    streak_d = 8'd0;
                end else if (dWEN || dREN) begin
                    state_d = dWEN ? StDWrite : StDRead;
                    // Only dcache grants that bypass a waiting icache count toward starvation.
                    if (iREN && streak_q < StarveMax) begin
                        streak_d = streak_q + 8'd1;
                    end
                end else if (iREN) begin
                    state_d  = StIRead;
                    streak_d = 8'd0;
                end
            end
            StDRead: begin
                ramREN   = 1'b1;
                ramaddr  = daddr;
                ramstore = dstore;
                if (done) begin
                    dwait   = 1'b0;
                    dload   = rdata;
                    state_d = StIdle;
                end else if (!dREN) begin
                    state_d = StIdle;
                end
            end
            StDWrite: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr;
                ramstore = dstore;
                if (done) begin
                    dwait   = 1'b0;
                    dload   = (ramstate == RamError) ? ERR_WORD : 32'd0;
                    state_d = StIdle;
                end else if (!dWEN) begin
                    state_d = StIdle;
                end
            end
            StIRead: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (done) begin
                    iwait   = 1'b0;
                    iload   = rdata;
                    state_d = StIdle;
                end else if (!iREN) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && ramstate == RamError && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a per-cycle ownership model checks every output,
// and literal expectations pin the key scenarios.
module tb_cache_mem_arbiter;

    localparam int          STARVE = 4;
    localparam logic [31:0] ERRW   = 32'hBAD1BAD1;
    localparam int OWN_NONE = 0, OWN_DRD = 1, OWN_DWR = 2, OWN_IRD = 3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: who owns the RAM, how many icache-bypassing dcache grants, error tally.
    int m_owner  = OWN_NONE;
    int m_streak = 0;
    int m_err    = 0;

    cache_mem_arbiter #(.STARVE_MAX(STARVE), .ERR_WORD(ERRW)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        bit fin;
        fin = (ramstate == 2'd2) || (ramstate == 2'd3);
        if (!nRST) begin
            m_owner = OWN_NONE; m_streak = 0; m_err = 0;
        end else if (m_owner == OWN_NONE) begin
            if (iREN && m_streak == STARVE) begin
                m_owner = OWN_IRD; m_streak = 0;
            end else if (dREN || dWEN) begin
                m_owner  = dWEN ? OWN_DWR : OWN_DRD;
                m_streak = iREN ? ((m_streak + 1 > STARVE) ? STARVE : m_streak + 1) : 0;
            end else if (iREN) begin
                m_owner = OWN_IRD; m_streak = 0;
            end else begin
                m_streak = 0;
            end
        end else begin
            if (fin) begin
                if (ramstate == 2'd3 && m_err < 255) m_err++;
                m_owner = OWN_NONE;
            end else if ((m_owner == OWN_DRD && !dREN) || (m_owner == OWN_DWR && !dWEN)
                         || (m_owner == OWN_IRD && !iREN)) begin
                m_owner = OWN_NONE;
            end
        end
    end

    function automatic logic [139:0] model_out();
        logic        ew, edw, er, ewr;
        logic [31:0] el, edl, ea, es, data;
        bit          fin;
        ew = 1; edw = 1; er = 0; ewr = 0; el = 0; edl = 0; ea = 0; es = 0;
        fin  = (ramstate == 2'd2) || (ramstate == 2'd3);
        data = (ramstate == 2'd3) ? ERRW : ramload;
        if (m_owner == OWN_DRD || m_owner == OWN_DWR) begin
            er = (m_owner == OWN_DRD); ewr = (m_owner == OWN_DWR);
            ea = daddr; es = dstore;
            if (fin) begin
                edw = 0;
                edl = (m_owner == OWN_DWR && ramstate == 2'd2) ? 32'd0 : data;
            end
        end else if (m_owner == OWN_IRD) begin
            er = 1; ea = iaddr;
            if (fin) begin ew = 0; el = data; end
        end
        return {ew, el, edw, edl, er, ewr, ea, es, 8'(m_err)};
    endfunction

    always @(negedge CLK) begin
        logic [139:0] act, exp;
        if (chk_en) begin
            act = {iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err_count};
            exp = model_out();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL outputs @%0t: got %h expected %h", $time, act, exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        string seq;
        int    dcnt;
        nRST = 0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 0;
        cyc(2);
        chk_en = 1;
        @(negedge CLK);
        chk("rst_iwait", 32'(iwait), 1);
        chk("rst_dwait", 32'(dwait), 1);
        chk("rst_strobes", {30'd0, ramREN, ramWEN}, 0);
        chk("rst_err", 32'(err_count), 0);
        @(posedge CLK); #1;
        nRST = 1;
        cyc(1);

        // dcache read, two BUSY cycles then ACCESS
        dREN = 1; daddr = 32'h40; ramstate = 2'd1; ramload = 32'hCAFE0001;
        cyc(1);
        cyc(2);
        ramstate = 2'd2;
        @(negedge CLK);
        chk("dread_dwait", 32'(dwait), 0);
        chk("dread_dload", dload, 32'hCAFE0001);
        @(posedge CLK); #1;
        dREN = 0; ramstate = 2'd0;
        @(negedge CLK);
        chk("dread_idle", {30'd0, ramREN, dwait}, 32'd1);
        cyc(1);

        // dcache write
        dWEN = 1; daddr = 32'h44; dstore = 32'h12345678; ramstate = 2'd1;
        cyc(2);
        @(negedge CLK);
        chk("dwrite_wen", 32'(ramWEN), 1);
        chk("dwrite_addr", ramaddr, 32'h44);
        chk("dwrite_store", ramstore, 32'h12345678);
        @(posedge CLK); #1;
        ramstate = 2'd2;
        @(negedge CLK);
        chk("dwrite_done", {31'd0, dwait}, 0);
        @(posedge CLK); #1;
        dWEN = 0; ramstate = 2'd0;
        cyc(1);

        // starvation: iREN and dREN held together
        iREN = 1; dREN = 1; daddr = 32'h80; iaddr = 32'h100; ramstate = 2'd2;
        ramload = 32'h0000ABCD;
        seq = ""; dcnt = 0;
        for (int k = 0; k < 40 && dcnt < 6; k++) begin
            @(negedge CLK);
            if (!dwait) begin seq = {seq, "D"}; dcnt++; end
            if (!iwait) seq = {seq, "I"};
            @(posedge CLK); #1;
        end
        checks++;
        if (seq != "DDDDIDD") begin
            errors++;
            $display("FAIL starve_seq: got %s expected DDDDIDD", seq);
        end
        iREN = 0; dREN = 0; ramstate = 2'd0;
        cyc(1);

        // ERROR completions on icache, then saturation
        iREN = 1; iaddr = 32'h200; ramstate = 2'd3; ramload = 32'h55;
        cyc(1);
        @(negedge CLK);
        chk("ierr_iwait", 32'(iwait), 0);
        chk("ierr_iload", iload, ERRW);
        @(posedge CLK); #1;
        chk("ierr_count1", 32'(err_count), 1);
        cyc(600);
        iREN = 0;
        cyc(2);
        ramstate = 2'd0;
        chk("ierr_sat", 32'(err_count), 255);

        // dREN dropped while granted and BUSY
        dREN = 1; daddr = 32'h60; ramstate = 2'd1;
        cyc(2);
        dREN = 0;
        @(negedge CLK);
        chk("drop_dwait", 32'(dwait), 1);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("drop_idle", {30'd0, ramREN, ramWEN}, 0);
        cyc(1);

        // simultaneous dREN/dWEN is a write
        dREN = 1; dWEN = 1; daddr = 32'h90; dstore = 32'h11112222; ramstate = 2'd2;
        cyc(1);
        @(negedge CLK);
        chk("both_strobes", {30'd0, ramREN, ramWEN}, 1);
        @(posedge CLK); #1;
        dREN = 0; dWEN = 0;
        cyc(1);

        // plain icache read
        iREN = 1; iaddr = 32'h300; ramload = 32'hDEADBEEF; ramstate = 2'd2;
        cyc(1);
        @(negedge CLK);
        chk("iread_iload", iload, 32'hDEADBEEF);
        @(posedge CLK); #1;
        iREN = 0;
        cyc(1);

        // reset in the middle of a write
        dWEN = 1; daddr = 32'h70; dstore = 32'hA5A5A5A5; ramstate = 2'd1;
        cyc(2);
        nRST = 0;
        cyc(1);
        chk("rstmid_wen", 32'(ramWEN), 0);
        chk("rstmid_addr", ramaddr, 0);
        chk("rstmid_store", ramstore, 0);
        chk("rstmid_waits", {30'd0, iwait, dwait}, 32'd3);
        chk("rstmid_err", 32'(err_count), 0);
        nRST = 1; dWEN = 0; ramstate = 2'd0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
